seg_scan_ctrl: RTL and testbench
================================

SEG_SCAN_CTRL -- requirements
Module: seg_scan_ctrl

Interface
REQ-001 Parameter N_DIGITS, default 4: number of multiplexed digits, range 2..8.
REQ-002 Parameter SCAN_DIV, default 100000: clk_in cycles each digit is lit (SHOW phase), range 2..2^20.
REQ-003 Parameter BLANK_CYC, default 1000: clk_in cycles all digits are dark before each SHOW (anti-ghosting), range 1..2^16.
REQ-004 clk_in  input  1: single clock; all state on its rising edge.
REQ-005 reset  input  1: asynchronous assert, active-low; synchronous deassert handled externally.
REQ-006 en  input  1: scan enable; 0 forces display dark.
REQ-007 digits_in  input  4*N_DIGITS: hex nibbles; nibble k (bits 4k+3:4k) drives digit k, digit 0 rightmost.
REQ-008 dp_in  input  N_DIGITS: decimal point per digit, 1 = lit.
REQ-009 sevenSeg  output  7: segments {g,f,e,d,c,b,a}, active-low.
REQ-010 dp  output  1: decimal point, active-low.
REQ-011 anodes  output  N_DIGITS: digit selects, active-low, at most one low at any time.
REQ-012 digit_idx  output  $clog2(N_DIGITS): index of digit currently selected or about to be.
REQ-013 frame_done  output  1: one-cycle pulse after the last digit's SHOW phase ends.

Function
REQ-014 The FSM SHALL have states IDLE, BLANK and SHOW, with one shared phase counter.
REQ-015 In IDLE with en=1, the next edge SHALL enter BLANK with digit_idx=0 and latch digits_in/dp_in into a frame snapshot.
REQ-016 BLANK SHALL last exactly BLANK_CYC cycles with anodes all 1 and sevenSeg/dp all 1, then enter SHOW.
REQ-017 SHOW SHALL last exactly SCAN_DIV cycles with anodes[digit_idx]=0 and sevenSeg/dp decoded from snapshot nibble digit_idx.
REQ-018 At SHOW end with digit_idx<N_DIGITS-1, it SHALL increment digit_idx and enter BLANK.
REQ-019 At SHOW end with digit_idx=N_DIGITS-1, it SHALL wrap digit_idx to 0, pulse frame_done for one cycle, re-latch the snapshot and enter BLANK.
REQ-020 Outputs SHALL be registered: anodes/sevenSeg/dp change on the same edge as the state transition, never mid-phase.
REQ-021 Input changes outside a frame boundary SHALL NOT affect the display until the next snapshot latch (no tearing).
REQ-022 en=0 in any state SHALL, on the next edge, enter IDLE: anodes, sevenSeg and dp all 1, digit_idx 0, counter 0, frame_done 0; a frame_done pending that edge is suppressed.
REQ-023 Decoding SHALL cover 0-9 and A-F with the standard hex glyphs (0 -> 7'b1000000, 8 -> 7'b0000000).

Reset
REQ-024 While reset=0: state IDLE, anodes all 1, sevenSeg 7'h7F, dp 1, digit_idx 0, frame_done 0, counter 0, snapshot 0.
REQ-025 Reset asserted mid-SHOW SHALL darken the display immediately (asynchronously), and after release operation SHALL restart from IDLE.

Configuration
REQ-026 Macro SEG_SCAN_LZB_EN defined: digits above the highest non-zero snapshot nibble SHALL display blank (sevenSeg 7'h7F) unless their dp_in bit is set; digit 0 SHALL always display.
REQ-027 SEG_SCAN_LZB_EN undefined: every digit SHALL display its nibble, leading zeros included; timing is identical either way.

Structure
REQ-028 Package seg_scan_pkg SHALL hold the state enum, the 16-entry glyph constant table and SEG_OFF=7'h7F.
REQ-029 Sub-module seg_hex_decoder (4-bit in, 7-bit active-low out, combinational) SHALL perform decoding.
REQ-030 Phase counter width SHALL be $clog2(max(SCAN_DIV,BLANK_CYC)+1); no other counters.

Verification (N_DIGITS=4, SCAN_DIV=4, BLANK_CYC=1)
REQ-031 Reset, en=1, digits_in=16'h1234 -> sequence: 1 dark cycle, 4 cycles anodes=4'b1110 sevenSeg=7'b0011001 ("4"), 1 dark cycle, then anodes=4'b1101 "3", and so on; frame_done pulses every 20 cycles.
REQ-032 digits_in changed 16'h1234->16'hABCD during digit 2 -> remaining digits of the frame still show 1,2; the next frame shows D,C,B,A.
REQ-033 en dropped mid-SHOW of digit 1 -> next edge anodes=4'hF, digit_idx=0, no frame_done; en re-raised -> restarts at digit 0 after BLANK.
REQ-034 reset pulsed low mid-SHOW -> anodes=4'hF without a clock edge; after release the full 20-cycle frame repeats from digit 0.
REQ-035 SEG_SCAN_LZB_EN defined, digits_in=16'h0050, dp_in=4'b0000 -> digits 3 and 2 blank, digit 1 "5", digit 0 "0"; undefined -> "0050".
REQ-036 All runs: assertion that anodes never has more than one bit low and is all 1 throughout every BLANK cycle.

Source files
------------

// File: rtl/seg_scan_pkg.sv
// ============================================================================
// Module      : seg_scan_pkg
// Description : Shared types and constants for the seven-segment scan controller.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package seg_scan_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BLANK = 2'd1,
        ST_SHOW  = 2'd2
    } state_t;

    localparam logic [6:0] SEG_OFF = 7'h7F;

    // Active-low glyphs {g,f,e,d,c,b,a}, indexed by hex value 0..F
    localparam logic [6:0] GLYPH [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };

endpackage

`default_nettype wire

// File: rtl/seg_hex_decoder.sv
// ============================================================================
// Module      : seg_hex_decoder
// Description : Combinational hex nibble to active-low seven-segment glyph.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module seg_hex_decoder
    import seg_scan_pkg::*;
(
    input  logic [3:0] hex_i,
    output logic [6:0] seg_o
);

    assign seg_o = GLYPH[hex_i];

endmodule

`default_nettype wire

// File: rtl/seg_scan_ctrl.sv
// ============================================================================
// Module      : seg_scan_ctrl
// Description : Multiplexed seven-segment scanner with anti-ghosting blank
//               phase and per-frame input snapshot. Define SEG_SCAN_LZB_EN
//               to blank leading zeros.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module seg_scan_ctrl
    import seg_scan_pkg::*;
#(
    parameter int N_DIGITS  = 4,
    parameter int SCAN_DIV  = 100000,
    parameter int BLANK_CYC = 1000
) (
    input  logic                          clk_in,
    input  logic                          reset,
    input  logic                          en,
    input  logic [4*N_DIGITS-1:0]         digits_in,
    input  logic [N_DIGITS-1:0]           dp_in,
    output logic [6:0]                    sevenSeg,
    output logic                          dp,
    output logic [N_DIGITS-1:0]           anodes,
    output logic [$clog2(N_DIGITS)-1:0]   digit_idx,
    output logic                          frame_done
);

    localparam int IDX_W   = $clog2(N_DIGITS);
    localparam int CNT_MAX = (SCAN_DIV > BLANK_CYC) ? SCAN_DIV : BLANK_CYC;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYC - 1);
    localparam logic [CNT_W-1:0] SHOW_LAST  = CNT_W'(SCAN_DIV - 1);
    localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(N_DIGITS - 1);

    state_t                state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [IDX_W-1:0]      idx_q, idx_d;
    logic [4*N_DIGITS-1:0] snap_q, snap_d;
    logic [N_DIGITS-1:0]   snap_dp_q, snap_dp_d;
    logic [N_DIGITS-1:0]   an_q, an_d;
    logic [6:0]            seg_q, seg_d;
    logic                  dp_q, dp_d;
    logic                  fd_q, fd_d;

    logic [3:0]            w_nibble;
    logic [6:0]            w_glyph;
    logic                  w_dp_bit;
    logic                  w_blank_digit;

    assign w_nibble = snap_q[{idx_q, 2'b00} +: 4];
    assign w_dp_bit = snap_dp_q[idx_q];

    seg_hex_decoder u_dec (
        .hex_i (w_nibble),
        .seg_o (w_glyph)
    );

`ifdef SEG_SCAN_LZB_EN
    logic [IDX_W-1:0] w_top_nz;

    // Digit 0 is never above w_top_nz, so it always displays
    always_comb begin
        w_top_nz = '0;
        for (int k = 1; k < N_DIGITS; k++) begin
            if (snap_q[4*k +: 4] != 4'h0) begin
                w_top_nz = IDX_W'(k);
            end
        end
    end

    assign w_blank_digit = (idx_q > w_top_nz) && !w_dp_bit;
`else
    assign w_blank_digit = 1'b0;
`endif

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q + CNT_W'(1);
        idx_d     = idx_q;
        snap_d    = snap_q;
        snap_dp_d = snap_dp_q;
        an_d      = an_q;
        seg_d     = seg_q;
        dp_d      = dp_q;
        fd_d      = 1'b0;

        case (state_q)
            ST_IDLE: begin
                cnt_d = '0;
                if (en) begin
                    state_d   = ST_BLANK;
                    idx_d     = '0;
                    snap_d    = digits_in;
                    snap_dp_d = dp_in;
                end
            end
            ST_BLANK: begin
                if (cnt_q == BLANK_LAST) begin
                    state_d = ST_SHOW;
                    cnt_d   = '0;
                    an_d    = ~({{(N_DIGITS-1){1'b0}}, 1'b1} << idx_q);
                    seg_d   = w_blank_digit ? SEG_OFF : w_glyph;
                    dp_d    = ~w_dp_bit;
                end
            end
            ST_SHOW: begin
                if (cnt_q == SHOW_LAST) begin
                    state_d = ST_BLANK;
                    cnt_d   = '0;
                    an_d    = '1;
                    seg_d   = SEG_OFF;
                    dp_d    = 1'b1;
                    if (idx_q == IDX_LAST) begin
                        idx_d     = '0;
                        fd_d      = 1'b1;
                        snap_d    = digits_in;
                        snap_dp_d = dp_in;
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Disable overrides everything, including a frame_done due this edge
        if (!en) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
            idx_d   = '0;
            an_d    = '1;
            seg_d   = SEG_OFF;
            dp_d    = 1'b1;
            fd_d    = 1'b0;
        end
    end

    always_ff @(posedge clk_in or negedge reset) begin
        if (!reset) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            idx_q     <= '0;
            snap_q    <= '0;
            snap_dp_q <= '0;
            an_q      <= '1;
            seg_q     <= SEG_OFF;
            dp_q      <= 1'b1;
            fd_q      <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            idx_q     <= idx_d;
            snap_q    <= snap_d;
            snap_dp_q <= snap_dp_d;
            an_q      <= an_d;
            seg_q     <= seg_d;
            dp_q      <= dp_d;
            fd_q      <= fd_d;
        end
    end

    assign anodes     = an_q;
    assign sevenSeg   = seg_q;
    assign dp         = dp_q;
    assign digit_idx  = idx_q;
    assign frame_done = fd_q;

endmodule

`default_nettype wire

// File: tb/tb_seg_scan_ctrl.sv
// ============================================================================
// Module      : tb_seg_scan_ctrl
// Description : Scoreboard bench for seg_scan_ctrl (N_DIGITS=4, SCAN_DIV=4,
//               BLANK_CYC=1); expectations follow SEG_SCAN_LZB_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_seg_scan_ctrl;
    import seg_scan_pkg::*;

    logic        clk_in = 1'b0;
    logic        reset  = 1'b1;
    logic        en     = 1'b0;
    logic [15:0] digits_in = 16'h0000;
    logic [3:0]  dp_in  = 4'b0000;
    logic [6:0]  sevenSeg;
    logic        dp;
    logic [3:0]  anodes;
    logic [1:0]  digit_idx;
    logic        frame_done;

    seg_scan_ctrl #(
        .N_DIGITS  (4),
        .SCAN_DIV  (4),
        .BLANK_CYC (1)
    ) dut (
        .clk_in     (clk_in),
        .reset      (reset),
        .en         (en),
        .digits_in  (digits_in),
        .dp_in      (dp_in),
        .sevenSeg   (sevenSeg),
        .dp         (dp),
        .anodes     (anodes),
        .digit_idx  (digit_idx),
        .frame_done (frame_done)
    );

    always #5 clk_in = ~clk_in;

    typedef struct packed {
        logic [3:0] an;
        logic [6:0] seg;
        logic       dp;
        logic       fd;
        logic [1:0] idx;
    } exp_t;

    localparam logic [6:0] G0 = 7'b1000000;
    localparam logic [6:0] G1 = 7'b1111001;
    localparam logic [6:0] G2 = 7'b0100100;
    localparam logic [6:0] G3 = 7'b0110000;
    localparam logic [6:0] G4 = 7'b0011001;
    localparam logic [6:0] G5 = 7'b0010010;
    localparam logic [6:0] GA = 7'b0001000;
    localparam logic [6:0] GB = 7'b0000011;
    localparam logic [6:0] GC = 7'b1000110;
    localparam logic [6:0] GD = 7'b0100001;
    localparam logic [6:0] GOFF = 7'h7F;
`ifdef SEG_SCAN_LZB_EN
    localparam logic [6:0] GLZ = GOFF;
`else
    localparam logic [6:0] GLZ = G0;
`endif

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    exp_t mon_exp;
    exp_t mon_got;

    // Each tick names the outputs expected after the next rising edge
    task automatic tick(input logic [3:0] an, input logic [6:0] seg, input logic dpv,
                        input logic fd, input logic [1:0] idx);
        exp_t e;
        e.an = an; e.seg = seg; e.dp = dpv; e.fd = fd; e.idx = idx;
        @(posedge clk_in);
        exp_q.push_back(e);
        #1;
    endtask

    task automatic dark(input logic fd, input logic [1:0] idx);
        tick(4'hF, GOFF, 1'b1, fd, idx);
    endtask

    task automatic show(input int k, input logic [6:0] g, input logic dp_lit, input int n);
        logic [3:0] a;
        a = 4'b0001 << k;
        for (int i = 0; i < n; i++) tick(~a, g, ~dp_lit, 1'b0, 2'(k));
    endtask

    task automatic check_now(input string name, input exp_t e);
        exp_t g;
        g = '{anodes, sevenSeg, dp, frame_done, digit_idx};
        checks++;
        if (g !== e) begin
            errors++;
            $display("FAIL %s: got an=%b seg=%b dp=%b fd=%b idx=%0d, required an=%b seg=%b dp=%b fd=%b idx=%0d",
                     name, g.an, g.seg, g.dp, g.fd, g.idx, e.an, e.seg, e.dp, e.fd, e.idx);
        end
    endtask

    // Scoreboard monitor
    initial begin
        forever begin
            @(negedge clk_in);
            if (exp_q.size() > 0) begin
                mon_exp = exp_q.pop_front();
                mon_got = '{anodes, sevenSeg, dp, frame_done, digit_idx};
                checks++;
                if (mon_got !== mon_exp) begin
                    errors++;
                    $display("FAIL scan t=%0t: got an=%b seg=%b dp=%b fd=%b idx=%0d, required an=%b seg=%b dp=%b fd=%b idx=%0d",
                             $time, mon_got.an, mon_got.seg, mon_got.dp, mon_got.fd, mon_got.idx,
                             mon_exp.an, mon_exp.seg, mon_exp.dp, mon_exp.fd, mon_exp.idx);
                end
            end
        end
    end

    // Anode invariants every cycle
    initial begin
        forever begin
            @(negedge clk_in);
            checks++;
            if ($countones(~anodes) > 1 || (dut.state_q == ST_BLANK && anodes !== 4'hF)) begin
                errors++;
                $display("FAIL anode_invariant t=%0t: got an=%b, required at most one low and all high in BLANK",
                         $time, anodes);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, required end of stimulus");
        $fatal(1, "watchdog");
    end

    initial begin
        digits_in = 16'h1234;
        dp_in     = 4'b0001;
        #2 reset = 1'b0;
        repeat (2) @(posedge clk_in);
        #1;
        check_now("reset_state", '{4'hF, GOFF, 1'b1, 1'b0, 2'd0});
        en    = 1'b1;
        reset = 1'b1;

        // Frame 1, inputs change mid digit 2 without tearing
        dark(0, 0); show(0, G4, 1, 4);
        dark(0, 1); show(1, G3, 0, 4);
        dark(0, 2); show(2, G2, 0, 1);
        digits_in = 16'hABCD;
        dp_in     = 4'b0000;
        show(2, G2, 0, 3);
        dark(0, 3); show(3, G1, 0, 4);

        // Frame 2 shows the new snapshot
        dark(1, 0); show(0, GD, 0, 4);
        dark(0, 1); show(1, GC, 0, 4);
        dark(0, 2); show(2, GB, 0, 4);
        dark(0, 3); show(3, GA, 0, 4);

        // Disable mid digit 1, then restart at digit 0
        dark(1, 0); show(0, GD, 0, 4);
        dark(0, 1); show(1, GC, 0, 2);
        en = 1'b0;
        dark(0, 0); dark(0, 0);
        en = 1'b1;
        dark(0, 0); show(0, GD, 0, 4);
        dark(0, 1); show(1, GC, 0, 4);
        dark(0, 2); show(2, GB, 0, 4);
        dark(0, 3); show(3, GA, 0, 4);

        // Disable on the last SHOW cycle suppresses frame_done
        en = 1'b0;
        dark(0, 0);

        // Leading-zero frames
        digits_in = 16'h0050;
        dp_in     = 4'b0000;
        en        = 1'b1;
        dark(0, 0);
        dp_in = 4'b1000;
        show(0, G0, 0, 4);
        dark(0, 1); show(1, G5, 0, 4);
        dark(0, 2); show(2, GLZ, 0, 4);
        dark(0, 3); show(3, GLZ, 0, 4);
        dark(1, 0); show(0, G0, 0, 4);
        dark(0, 1); show(1, G5, 0, 4);
        dark(0, 2); show(2, GLZ, 0, 4);
        dark(0, 3); show(3, G0, 1, 4);

        // Asynchronous reset mid SHOW of digit 2
        digits_in = 16'h1234;
        dp_in     = 4'b0000;
        dark(1, 0); show(0, G4, 0, 4);
        dark(0, 1); show(1, G3, 0, 4);
        dark(0, 2); show(2, G2, 0, 2);
        @(negedge clk_in);
        #1 reset = 1'b0;
        #1;
        check_now("async_reset_dark", '{4'hF, GOFF, 1'b1, 1'b0, 2'd0});
        repeat (2) @(posedge clk_in);
        #1 reset = 1'b1;
        dark(0, 0); show(0, G4, 0, 4);
        dark(0, 1); show(1, G3, 0, 4);
        dark(0, 2); show(2, G2, 0, 4);
        dark(0, 3); show(3, G1, 0, 4);
        dark(1, 0);

        @(negedge clk_in);
        #1;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d pending, required 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
